// File: rtl/simpleuart_fifo.sv
// simpleuart_fifo: TX and RX byte queues between the CPU data register and
// simpleuart. TX drains into simpleuart, honouring its reg_dat_wait stall.
// RX empties simpleuart's single-byte buffer as soon as a byte lands.
// A status word reports the queue counts, the RX drop count and the flags.
module simpleuart_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_dat_we,
  input  logic [31:0] cpu_dat_di,
  output logic        cpu_dat_wait,
  input  logic        cpu_dat_re,
  output logic [31:0] cpu_dat_do,
  output logic [31:0] cpu_stat_do,
  output logic        uart_dat_we,
  output logic [31:0] uart_dat_di,
  input  logic        uart_dat_wait,
  output logic        uart_dat_re,
  input  logic [31:0] uart_dat_do
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [31:0]           NO_BYTE    = 32'hffff_ffff;

  // Queue storage and bookkeeping
  logic [7:0]            r_tx_mem [DEPTH];
  logic [7:0]            r_rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [DEPTH_LOG2:0]   r_tx_count, r_rx_count;
  logic [7:0]            r_rx_drop;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_rx_valid, w_rx_push, w_rx_drop, w_rx_pop;
  logic w_unused_bits;

  // Flags come from the pre-edge counts, so a same-cycle pop never frees a
  // slot for a push when full, and a same-cycle push never feeds a pop when empty.
  assign w_tx_full  = (r_tx_count == FULL_COUNT);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == FULL_COUNT);
  assign w_rx_empty = (r_rx_count == '0);

  assign w_tx_push  = cpu_dat_we && !w_tx_full;
  assign w_tx_pop   = !w_tx_empty && !uart_dat_wait;  // simpleuart's accept condition
  assign w_rx_valid = (uart_dat_do != NO_BYTE);
  assign w_rx_push  = w_rx_valid && !w_rx_full;
  assign w_rx_drop  = w_rx_valid && w_rx_full;
  assign w_rx_pop   = cpu_dat_re && !w_rx_empty;

  // Bus-side outputs: only the stall and the UART read strobe depend on inputs.
  assign cpu_dat_wait = cpu_dat_we && w_tx_full;
  assign cpu_dat_do   = w_rx_empty ? NO_BYTE : {24'h0, r_rx_mem[r_rx_rd]};
  assign cpu_stat_do  = {6'h0, w_rx_empty, w_tx_full, r_rx_drop,
                         8'(r_rx_count), 8'(r_tx_count)};
  // The head slot holds stale data when empty; mask it so the bus reads zero.
  assign uart_dat_we  = !w_tx_empty;
  assign uart_dat_di  = w_tx_empty ? 32'h0 : {24'h0, r_tx_mem[r_tx_rd]};
  assign uart_dat_re  = resetn && w_rx_valid;

  assign w_unused_bits = ^cpu_dat_di[31:8];

  // Data storage writes; pointers alone decide which entries are live.
  // NOTE: the byte arrays carry no reset -- clearing pointers and counts is
  // enough to discard contents, and a resettable array cannot map onto RAM.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= cpu_dat_di[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr] <= uart_dat_do[7:0];
  end

  // TX pointers and count: CPU pushes at the tail, simpleuart pops the head.
  // NOTE: state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + CNT_ONE;
        2'b01:   r_tx_count <= r_tx_count - CNT_ONE;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // RX pointers, count and saturating drop counter: simpleuart pushes, CPU pops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
      r_rx_drop  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CNT_ONE;
        2'b01:   r_rx_count <= r_rx_count - CNT_ONE;
        default: r_rx_count <= r_rx_count;
      endcase
      if (w_rx_drop && (r_rx_drop != 8'hff)) r_rx_drop <= r_rx_drop + 8'd1;
    end
  end

endmodule

// File: tb/tb_simpleuart_fifo.sv
// Directed bench for simpleuart_fifo (DEPTH_LOG2 = 4). Inputs change and
// outputs are sampled around the falling edge; the DUT updates on the rising edge.
module tb_simpleuart_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_dat_we;
  logic [31:0] cpu_dat_di;
  logic        cpu_dat_wait;
  logic        cpu_dat_re;
  logic [31:0] cpu_dat_do;
  logic [31:0] cpu_stat_do;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;
  logic        uart_dat_re;
  logic [31:0] uart_dat_do;

  int n_cmp = 0;
  int n_err = 0;

  simpleuart_fifo #(.DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cpu_dat_we    (cpu_dat_we),
    .cpu_dat_di    (cpu_dat_di),
    .cpu_dat_wait  (cpu_dat_wait),
    .cpu_dat_re    (cpu_dat_re),
    .cpu_dat_do    (cpu_dat_do),
    .cpu_stat_do   (cpu_stat_do),
    .uart_dat_we   (uart_dat_we),
    .uart_dat_di   (uart_dat_di),
    .uart_dat_wait (uart_dat_wait),
    .uart_dat_re   (uart_dat_re),
    .uart_dat_do   (uart_dat_do)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Safety net against a hung run.
  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] tx_bytes [3];
    tx_bytes[0] = 8'h13;
    tx_bytes[1] = 8'h55;
    tx_bytes[2] = 8'hA0;

    // ---- Reset: 2 clocks low; a byte offered meanwhile must not be read ----
    resetn        = 1'b0;
    cpu_dat_we    = 1'b0;
    cpu_dat_di    = 32'h0;
    cpu_dat_re    = 1'b0;
    uart_dat_wait = 1'b0;
    uart_dat_do   = 32'h0000_005A;
    #1;
    check("re_forced_in_reset", {31'b0, uart_dat_re}, 32'd0);
    tick();
    tick();
    uart_dat_do = 32'hffff_ffff;
    resetn      = 1'b1;
    #1;
    check("rst_cpu_do",   cpu_dat_do,  32'hffff_ffff);
    check("rst_stat",     cpu_stat_do, 32'h0200_0000);
    check("rst_uart_we",  {31'b0, uart_dat_we},  32'd0);
    check("rst_uart_re",  {31'b0, uart_dat_re},  32'd0);
    check("rst_cpu_wait", {31'b0, cpu_dat_wait}, 32'd0);
    check("rst_uart_di",  uart_dat_di, 32'h0);

    // ---- TX drain: three back-to-back writes, UART stalls 500 clocks/byte ----
    uart_dat_wait = 1'b1;
    cpu_dat_we    = 1'b1;
    cpu_dat_di    = 32'h13;
    #1 check("tx_w0_wait", {31'b0, cpu_dat_wait}, 32'd0);
    tick();
    cpu_dat_di = 32'h55;
    #1;
    check("tx_w1_wait", {31'b0, cpu_dat_wait}, 32'd0);
    check("tx_lat_we",  {31'b0, uart_dat_we},  32'd1);
    check("tx_lat_di",  uart_dat_di, 32'h13);
    tick();
    cpu_dat_di = 32'hA0;
    #1 check("tx_w2_wait", {31'b0, cpu_dat_wait}, 32'd0);
    tick();
    cpu_dat_we = 1'b0;
    #1 check("tx_count3", cpu_stat_do, 32'h0200_0003);
    for (int i = 0; i < 3; i++) begin
      #1 check("tx_head", uart_dat_di, {24'h0, tx_bytes[i]});
      repeat (500) tick();
      #1 check("tx_held_in_wait", uart_dat_di, {24'h0, tx_bytes[i]});
      uart_dat_wait = 1'b0;
      tick();
      uart_dat_wait = 1'b1;
    end
    #1;
    check("tx_drained_we",   {31'b0, uart_dat_we}, 32'd0);
    check("tx_drained_stat", cpu_stat_do, 32'h0200_0000);
    check("tx_drained_di",   uart_dat_di, 32'h0);

    // ---- TX full: 16 accepted, 17th stalls until one byte drains ----
    for (int i = 0; i < 16; i++) begin
      cpu_dat_we = 1'b1;
      cpu_dat_di = 32'(i + 1);
      #1 check("txf_fill_wait", {31'b0, cpu_dat_wait}, 32'd0);
      tick();
    end
    cpu_dat_di = 32'h11;
    #1;
    check("txf_17_wait", {31'b0, cpu_dat_wait}, 32'd1);
    check("txf_stat",    cpu_stat_do, 32'h0300_0010);
    tick();
    #1 check("txf_still_wait", {31'b0, cpu_dat_wait}, 32'd1);
    uart_dat_wait = 1'b0;
    #1 check("txf_wait_during_pop", {31'b0, cpu_dat_wait}, 32'd1);
    tick();
    uart_dat_wait = 1'b1;
    #1;
    check("txf_wait_drops", {31'b0, cpu_dat_wait}, 32'd0);
    check("txf_head_after", uart_dat_di, 32'h02);
    check("txf_stat_15",    cpu_stat_do, 32'h0200_000F);
    tick();
    cpu_dat_we = 1'b0;
    #1 check("txf_17_accepted", cpu_stat_do, 32'h0300_0010);
    uart_dat_wait = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 check("txf_drain_order", uart_dat_di, 32'(i + 2));
      tick();
    end
    #1 check("txf_empty_we", {31'b0, uart_dat_we}, 32'd0);

    // ---- TX simultaneous push and pop at count 1 ----
    cpu_dat_we = 1'b1;
    cpu_dat_di = 32'h99;
    tick();
    cpu_dat_di = 32'h9A;
    #1;
    check("txs_head0", uart_dat_di, 32'h99);
    check("txs_cnt0",  cpu_stat_do, 32'h0200_0001);
    tick();
    cpu_dat_we = 1'b0;
    #1;
    check("txs_head1", uart_dat_di, 32'h9A);
    check("txs_cnt1",  cpu_stat_do, 32'h0200_0001);
    tick();
    #1 check("txs_empty", {31'b0, uart_dat_we}, 32'd0);

    // ---- RX buffer: two single-cycle bytes, then reads ----
    uart_dat_do = 32'h13;
    #1 check("rx_re_b0", {31'b0, uart_dat_re}, 32'd1);
    tick();
    uart_dat_do = 32'hffff_ffff;
    #1;
    check("rx_re_idle", {31'b0, uart_dat_re}, 32'd0);
    check("rx_lat",     cpu_dat_do, 32'h13);
    uart_dat_do = 32'h7E;
    #1 check("rx_re_b1", {31'b0, uart_dat_re}, 32'd1);
    tick();
    uart_dat_do = 32'hffff_ffff;
    #1 check("rx_count2", cpu_stat_do, 32'h0000_0200);
    cpu_dat_re = 1'b1;
    #1 check("rx_rd0", cpu_dat_do, 32'h13);
    tick();
    #1 check("rx_rd1", cpu_dat_do, 32'h7E);
    tick();
    #1 check("rx_rd_empty", cpu_dat_do, 32'hffff_ffff);
    tick();
    #1;
    check("rx_rd_empty_again", cpu_dat_do, 32'hffff_ffff);
    check("rx_stat_empty",     cpu_stat_do, 32'h0200_0000);
    cpu_dat_re = 1'b0;

    // ---- RX overflow: 18 bytes with no reads, then full push+pop ----
    for (int i = 0; i < 18; i++) begin
      uart_dat_do = 32'(8'h40 + i);
      tick();
    end
    uart_dat_do = 32'hffff_ffff;
    #1 check("rxo_stat", cpu_stat_do, 32'h0002_1000);
    uart_dat_do = 32'h77;
    cpu_dat_re  = 1'b1;
    #1;
    check("rxo_head",        cpu_dat_do, 32'h40);
    check("rxo_re_when_full", {31'b0, uart_dat_re}, 32'd1);
    tick();
    uart_dat_do = 32'hffff_ffff;
    #1 check("rxo_full_drop", cpu_stat_do, 32'h0003_0F00);
    for (int i = 0; i < 15; i++) begin
      #1 check("rxo_drain_order", cpu_dat_do, 32'(8'h41 + i));
      tick();
    end
    #1;
    check("rxo_drained",    cpu_dat_do,  32'hffff_ffff);
    check("rxo_drop_holds", cpu_stat_do, 32'h0203_0000);
    cpu_dat_re = 1'b0;

    // ---- Reset mid-transfer discards both queues and rx_drop ----
    uart_dat_wait = 1'b1;
    cpu_dat_we    = 1'b1;
    cpu_dat_di    = 32'h31;
    tick();
    cpu_dat_we  = 1'b0;
    uart_dat_do = 32'h32;
    tick();
    uart_dat_do = 32'hffff_ffff;
    #1 check("mid_stat_before", cpu_stat_do, 32'h0003_0101);
    resetn = 1'b0;
    tick();
    resetn        = 1'b1;
    uart_dat_wait = 1'b0;
    #1;
    check("mid_uart_we", {31'b0, uart_dat_we}, 32'd0);
    check("mid_stat",    cpu_stat_do, 32'h0200_0000);
    check("mid_cpu_do",  cpu_dat_do,  32'hffff_ffff);

    // ---- Wrap: 40 bytes streamed while the CPU reads every cycle ----
    cpu_dat_re = 1'b1;
    for (int i = 0; i < 40; i++) begin
      uart_dat_do = 32'(8'h80 + i);
      #1;
      if (i == 0) begin
        check("wrap_first_empty", cpu_dat_do, 32'hffff_ffff);
      end else begin
        check("wrap_order", cpu_dat_do, 32'(8'h80 + i - 1));
        check("wrap_count1", cpu_stat_do, 32'h0000_0100);
      end
      tick();
    end
    uart_dat_do = 32'hffff_ffff;
    #1 check("wrap_last", cpu_dat_do, 32'hA7);
    tick();
    #1;
    check("wrap_empty", cpu_dat_do,  32'hffff_ffff);
    check("wrap_stat",  cpu_stat_do, 32'h0200_0000);
    cpu_dat_re = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
